// File: rtl/mux2_seq_pkg.sv
// Shared types and helpers for the mux2 vector sequencer.
package mux2_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_VEC = 8;

  // Reference behaviour of the downstream mux2.
  function automatic logic exp_out(input logic d0, input logic d1, input logic s);
    return s ? d1 : d0;
  endfunction

endpackage

// File: rtl/mux2_dwell_counter.sv
// Loadable down-counter that times how long each vector is held; last flags count==1.
module mux2_dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/mux2_vector_sequencer.sv
// Walks the 8 {data_in_0, data_in_1, sel} vectors with per-vector dwell times.
// Optional downstream checker compiled in with `MUX_SELF_CHECK_EN.
module mux2_vector_sequencer
  import mux2_seq_pkg::*;
#(
  parameter int LONG_DWELL  = 50,
  parameter int SHORT_DWELL = 10,
  parameter int CNT_W       = 8,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             data_in_0,
  output logic             data_in_1,
  output logic             sel,
  output logic [2:0]       vec_idx,
  output logic             busy,
  output logic             done,
  input  logic             mux_out,
  output logic [ERR_W-1:0] err_cnt
);

  if (LONG_DWELL < 1 || LONG_DWELL >= 2**CNT_W || SHORT_DWELL < 1 || SHORT_DWELL >= 2**CNT_W) begin : g_bad_dwell
    $error("mux2_vector_sequencer: dwell must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LONG_V  = CNT_W'(LONG_DWELL);
  localparam logic [CNT_W-1:0] SHORT_V = CNT_W'(SHORT_DWELL);
  localparam logic [2:0]       LAST_IDX = 3'(NUM_VEC - 1);

  state_t           state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic             load, last, accept;
  logic [CNT_W-1:0] load_val;

  assign accept = (state == IDLE) && start && !abort;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    load_val  = LONG_V;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = APPLY;
          idx_nxt   = '0;
          load      = 1'b1;
        end
      end
      APPLY: begin
        if (last) begin
          if (idx != LAST_IDX) begin
            idx_nxt  = idx + 3'd1;
            load     = 1'b1;
            // idx+1 of 0 or 4 means the vector about to start is 0 or 4
            load_val = (idx_nxt[1:0] == 2'b00) ? LONG_V : SHORT_V;
          end else begin
            state_nxt = DONE;
            idx_nxt   = '0;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      load      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  mux2_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .en       (state == APPLY),
    .last     (last)
  );

  assign vec_idx   = idx;
  assign data_in_0 = idx[2];
  assign data_in_1 = idx[1];
  assign sel       = idx[0];
  assign busy      = (state == APPLY);
  assign done      = (state == DONE);

`ifdef MUX_SELF_CHECK_EN
  logic [ERR_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= '0;
    else if (accept)
      err_q <= '0;
    else if (state == APPLY && last && mux_out != exp_out(idx[2], idx[1], idx[0]) && err_q != '1)
      err_q <= err_q + 1'b1;
  end

  assign err_cnt = err_q;
`else
  logic unused_mux_out;
  assign unused_mux_out = mux_out;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_mux2_vector_sequencer.sv
// Scoreboard bench for mux2_vector_sequencer: expected vector stream queued at start, popped while busy.
module tb_mux2_vector_sequencer;

  localparam int LONG  = 50;
  localparam int SHORT = 10;
  localparam int SWEEP = 2*LONG + 6*SHORT;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, mux_out, tie0;
  logic       data_in_0, data_in_1, sel, busy, done;
  logic [2:0] vec_idx;
  logic [3:0] err_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mux_out = tie0 ? 1'b0 : (sel ? data_in_1 : data_in_0);

  mux2_vector_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .data_in_0 (data_in_0),
    .data_in_1 (data_in_1),
    .sel       (sel),
    .vec_idx   (vec_idx),
    .busy      (busy),
    .done      (done),
    .mux_out   (mux_out),
    .err_cnt   (err_cnt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < ((i == 0 || i == 4) ? LONG : SHORT); k++)
        q.push_back(i);
  endtask

  always @(negedge clk) begin
    if (rst_n && busy) begin
      if (q.size() == 0) begin
        chk("sb_size", q.size(), 1);
      end else begin
        int e;
        e = q.pop_front();
        chk("vec_idx", int'(vec_idx), e);
        chk("dout", int'({data_in_0, data_in_1, sel}), e);
      end
    end
  end

  task automatic pulse_start(input bit push, output int t0);
    @(negedge clk);
    start = 1'b1;
    if (push) push_sweep();
    @(posedge clk);
    #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_idx(input int v);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && int'(vec_idx) == v) && n < 400);
    chk("reach_idx", int'(vec_idx), v);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_dout"}, int'({data_in_0, data_in_1, sel}), 0);
    chk({tag, "_idx"}, int'(vec_idx), 0);
  endtask

  task automatic wait_done(input int t0, input int exp_err);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 400);
    chk("done_seen", int'(done), 1);
    chk("sweep_len", cyc - t0, SWEEP);
    chk("sb_left", q.size(), 0);
    chk("err_cnt", int'(err_cnt), exp_err);
    chk("done_dout", int'({data_in_0, data_in_1, sel}), 0);
    @(negedge clk);
    check_idle_zero("post_done");
  endtask

  initial begin
    int t0, t1, ndone, nbusy, exp_tied;
`ifdef MUX_SELF_CHECK_EN
    exp_tied = 4;
`else
    exp_tied = 0;
`endif
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tie0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("reset");
    chk("reset_err", int'(err_cnt), 0);

    // full sweep, spot-check encodings
    pulse_start(1'b1, t0);
    @(negedge clk);
    chk("busy_rise", int'(busy), 1);
    wait_idx(5);
    chk("enc5", int'({data_in_0, data_in_1, sel}), 3'b101);
    wait_idx(6);
    chk("enc6", int'({data_in_0, data_in_1, sel}), 3'b110);
    wait_done(t0, 0);

    // start while busy is ignored
    pulse_start(1'b1, t0);
    wait_idx(3);
    pulse_start(1'b0, t1);
    wait_done(t0, 0);

    // abort mid-sweep
    pulse_start(1'b1, t0);
    wait_idx(2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle_zero("abort");
    q.delete();
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    // restart after abort with a stuck-low mux output
    tie0 = 1'b1;
    pulse_start(1'b1, t0);
    wait_done(t0, exp_tied);
    tie0 = 1'b0;

    // synchronous reset mid-sweep
    pulse_start(1'b1, t0);
    wait_idx(5);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_zero("mid_reset");
    chk("mid_reset_err", int'(err_cnt), 0);
    rst_n = 1'b1;
    q.delete();
    nbusy = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done) nbusy++;
    end
    chk("reset_stays_idle", nbusy, 0);

    // start and abort together: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", int'(busy), 0);

    // clean sweep afterwards
    pulse_start(1'b1, t0);
    wait_done(t0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
